online_adder_r4: RTL and testbench



---
 rtl/online_adder_r4.sv | 82 ++++++++
 tb/tb_online_adder_r4.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/online_adder_r4.sv
// rtl/online_adder_r4.sv - radix-4 MSD-first online signed-digit adder
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high clear of all state
//   en     advance enable; when low every register holds
//   xi     signed operand-x digit (C-bit two's complement, MSD first)
//   yi     signed operand-y digit (C-bit two's complement, MSD first)
//   zi     signed sum digit, one digit behind the operands, MSD first
module online_adder_r4 #(
    parameter int C = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [C-1:0] xi,
    input  logic [C-1:0] yi,
    output logic [C-1:0] zi
);

    // One extra bit keeps the position sum exact for any pair of digits.
    localparam int PW = C + 1;

    localparam logic signed [PW-1:0] P_POS2 = PW'(2);
    localparam logic signed [PW-1:0] P_NEG2 = PW'(-2);
    localparam logic        [C-1:0]  FOUR_C = C'(4);

    logic signed [C-1:0]  xr_q, xr_d;
    logic signed [C-1:0]  yr_q, yr_d;
    logic signed [C-1:0]  wr_q, wr_d;

    logic signed [PW-1:0] p;
    logic signed [1:0]    t;
    logic        [C-1:0]  w;
    logic        [C-1:0]  t_ext;

    // Position sum, transfer digit and interim sum from the registered digits.
    // The interim sum always lands in -2..2, so it is formed modulo 2^C from
    // the low bits of p; only the sign decision needs the full-width sum.
    always_comb begin
        p = {xr_q[C-1], xr_q} + {yr_q[C-1], yr_q};
        t = 2'sd0;
        w = p[C-1:0];
        if (p >= P_POS2) begin
            t = 2'sd1;
            w = p[C-1:0] - FOUR_C;
        end else if (p <= P_NEG2) begin
            t = -2'sd1;
            w = p[C-1:0] + FOUR_C;
        end
    end

    always_comb begin
        xr_d = xr_q;
        yr_d = yr_q;
        wr_d = wr_q;
        if (en) begin
            xr_d = xi;
            yr_d = yi;
            wr_d = w;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            xr_q <= '0;
            yr_q <= '0;
            wr_q <= '0;
        end else begin
            xr_q <= xr_d;
            yr_q <= yr_d;
            wr_q <= wr_d;
        end
    end

    // Output digit depends only on registers, never directly on xi/yi.
    always_comb begin
        t_ext = {{(C-2){t[1]}}, t};
        zi    = wr_q + t_ext;
    end

endmodule

// File: tb/tb_online_adder_r4.sv
// tb/tb_online_adder_r4.sv - directed self-checking bench for online_adder_r4
module tb_online_adder_r4;

    logic       clk;
    logic       reset;
    logic       en;
    logic [2:0] xi;
    logic [2:0] yi;
    logic [2:0] zi;

    int total;
    int passed;

    int xv [8][6];
    int yv [8][6];
    int zv [8][7];

    online_adder_r4 #(.C(3)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .xi    (xi),
        .yi    (yi),
        .zi    (zi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_z(input string tag, input int expected);
        logic [2:0] exp_bits;
        exp_bits = 3'(expected);
        total++;
        assert (zi === exp_bits) passed++;
        else $error("FAIL %s: zi=%0d required=%0d", tag, $signed(zi), expected);
    endtask

    task automatic check_known(input string tag);
        total++;
        assert (!$isunknown(zi)) passed++;
        else $error("FAIL %s: zi=%b required a known value", tag, zi);
    endtask

    // Runs operation k: optional reset pulse, one discarded lead edge,
    // six operand digits, then one zero digit to flush Z6.
    task automatic run_op(input int k, input bit do_reset);
        string tag;
        if (do_reset) begin
            reset = 1'b1;
            en    = 1'b1;
            xi    = 3'(2);
            yi    = 3'(-1);
            tick();
            $sformat(tag, "op%0d_reset", k);
            check_z(tag, 0);
            reset = 1'b0;
        end
        en = 1'b1;
        xi = '0;
        yi = '0;
        tick();
        $sformat(tag, "op%0d_lead", k);
        check_z(tag, 0);
        for (int i = 0; i < 6; i++) begin
            xi = 3'(xv[k][i]);
            yi = 3'(yv[k][i]);
            tick();
            $sformat(tag, "op%0d_Z%0d", k, i);
            check_z(tag, zv[k][i]);
            check_known(tag);
        end
        xi = '0;
        yi = '0;
        tick();
        $sformat(tag, "op%0d_Z6", k);
        check_z(tag, zv[k][6]);
        check_known(tag);
    endtask

    initial begin
        total  = 0;
        passed = 0;

        xv[0] = '{1, 0, 0, 0, 0, 0};       yv[0] = '{1, 0, 0, 0, 0, 0};
        zv[0] = '{1, -2, 0, 0, 0, 0, 0};
        xv[1] = '{3, 3, 3, 3, 3, 3};       yv[1] = '{3, 3, 3, 3, 3, 3};
        zv[1] = '{1, 3, 3, 3, 3, 3, 2};
        xv[2] = '{-3, -3, -3, -3, -3, -3}; yv[2] = '{-3, -3, -3, -3, -3, -3};
        zv[2] = '{-1, -3, -3, -3, -3, -3, -2};
        xv[3] = '{1, -1, 2, 0, 0, 0};      yv[3] = '{0, 0, 0, 0, 0, 1};
        zv[3] = '{0, 1, 0, -2, 0, 0, 1};
        xv[4] = '{2, 2, -2, 1, 0, -3};     yv[4] = '{1, -3, 0, 1, 2, 3};
        zv[4] = '{1, -1, -2, 3, -1, -2, 0};
        xv[5] = '{0, 0, 0, 0, 0, 3};       yv[5] = '{0, 0, 0, 0, 0, 3};
        zv[5] = '{0, 0, 0, 0, 0, 1, 2};
        xv[6] = '{-1, 1, -1, 1, -1, 1};    yv[6] = '{-1, 1, -1, 1, -1, 1};
        zv[6] = '{-1, 3, -3, 3, -3, 3, -2};
        xv[7] = '{3, -2, 1, 0, -1, 2};     yv[7] = '{-3, -1, 2, 1, 0, -1};
        zv[7] = '{0, -1, 2, -1, 1, -1, 1};

        reset = 1'b1;
        en    = 1'b0;
        xi    = '0;
        yi    = '0;
        tick();
        tick();
        check_z("reset_state", 0);
        reset = 1'b0;

        // Tests 1-4 in sequence.
        run_op(0, 1'b0);
        run_op(1, 1'b1);
        run_op(2, 1'b1);
        run_op(3, 1'b1);

        // Test 5: stall after Z2, then reset after Z3, then test 1.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        en = 1'b1;
        xi = '0;
        yi = '0;
        tick();
        check_z("stall_lead", 0);
        for (int i = 0; i < 3; i++) begin
            xi = 3'(3);
            yi = 3'(3);
            tick();
            check_z("stall_pre", zv[1][i]);
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            xi = 3'(-3);
            yi = 3'(1);
            tick();
            check_z("stall_hold", 3);
        end
        en = 1'b1;
        xi = 3'(3);
        yi = 3'(3);
        tick();
        check_z("stall_resume_Z3", 3);
        reset = 1'b1;
        en    = 1'b0;
        tick();
        check_z("reset_over_en", 0);
        reset = 1'b0;
        run_op(0, 1'b0);

        // Test 6: eight operations, each behind a reset pulse.
        for (int k = 0; k < 8; k++) run_op(k, 1'b1);

        // Out-of-contract -4 digits must still yield a defined output.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        en = 1'b1;
        xi = 3'b100;
        yi = 3'b100;
        tick();
        check_known("neg4_a");
        tick();
        check_known("neg4_b");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
